// File: rtl/ide_pkg.sv
// Shared definitions for the IDE PIO-mode-0 controller: FSM encoding, ATA task-file
// register addresses ({CS0 sel, CS1 sel, DA[2:0]} as seen by ide_pio_ctrl), status bits
// and the sector read/write command opcodes.
package ide_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StRecov
  } ide_state_e;

  // Command block (CS0-) registers
  localparam logic [4:0] ATA_DATA    = 5'b10000;
  localparam logic [4:0] ATA_SECCNT  = 5'b10010;
  localparam logic [4:0] ATA_SECNUM  = 5'b10011;
  localparam logic [4:0] ATA_CYLLOW  = 5'b10100;
  localparam logic [4:0] ATA_CYLHIGH = 5'b10101;
  localparam logic [4:0] ATA_DRVHEAD = 5'b10110;
  localparam logic [4:0] ATA_STATUS  = 5'b10111;
  localparam logic [4:0] ATA_COMMAND = 5'b10111;
  // Control block (CS1-) registers
  localparam logic [4:0] ATA_ALTER   = 5'b01110;
  localparam logic [4:0] ATA_DEVCTRL = 5'b01110;

  // Status register bit indices
  localparam int unsigned ATA_BSY  = 7;
  localparam int unsigned ATA_DRDY = 6;
  localparam int unsigned ATA_DRQ  = 3;
  localparam int unsigned ATA_ERR  = 0;

  localparam logic [7:0] ATA_CMD_READ  = 8'h20;
  localparam logic [7:0] ATA_CMD_WRITE = 8'h30;

endpackage

// File: rtl/ide_timer.sv
// Loadable 5-bit down-counter. expire is high while the count sits at 1, i.e. in the
// last cycle of the interval that was loaded.
module ide_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic       expire
);

  logic [4:0] count_q;

  // Load on state entry, otherwise count down and park at 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 5'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q > 5'd1) begin
      count_q <= count_q - 5'd1;
    end
  end

  assign expire = (count_q == 5'd1);

endmodule

// File: rtl/ide_pio_ctrl.sv
// ATA PIO-mode-0 register access engine: one task-file access per request with programmed
// setup / strobe / hold / recovery timing. Optional IORDY strobe stretching is enabled by
// defining IDE_IORDY_EN; without it the strobe width is exactly T_PULSE cycles.
module ide_pio_ctrl
  import ide_pkg::*;
#(
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_PULSE     = 9,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_RECOVER   = 16,
  parameter int unsigned T_IORDY_MAX = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ata_rd,
  input  logic        ata_wr,
  input  logic [4:0]  ata_addr,
  input  logic [15:0] ata_in,
  output logic [15:0] ata_out,
  output logic        ata_done,
  output logic        ata_busy,
  inout  wire  [15:0] ide_data_bus,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
`ifdef IDE_IORDY_EN
  ,
  input  logic        ide_iordy
`endif
);

  ide_state_e  state_q;
  logic        write_q;
  logic [15:0] wdata_q;
  logic        drive_q;
  logic        stretch_q;

  logic        iordy;
  logic        tmr_load;
  logic [4:0]  tmr_val;
  logic        tmr_expire;
  logic        pulse_end;
  logic        stretch_start;

  // Without IORDY support the device is always ready, so the stretch path folds away
`ifdef IDE_IORDY_EN
  assign iordy = ide_iordy;
`else
  assign iordy = 1'b1;
`endif

  assign ide_data_bus = drive_q ? wdata_q : 16'hzzzz;

  ide_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Timer reload on every state entry and end-of-strobe detection
  always_comb begin
    tmr_load      = 1'b0;
    tmr_val       = 5'(T_SETUP);
    pulse_end     = 1'b0;
    stretch_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (ata_rd || ata_wr) begin
          tmr_load = 1'b1;
          tmr_val  = 5'(T_SETUP);
        end
      end
      StSetup: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = 5'(T_PULSE);
        end
      end
      StPulse: begin
        if (stretch_q) begin
          pulse_end = iordy || tmr_expire;
        end else if (tmr_expire) begin
          pulse_end     = iordy;
          stretch_start = !iordy;
        end
        if (pulse_end) begin
          tmr_load = 1'b1;
          tmr_val  = 5'(T_HOLD);
        end else if (stretch_start) begin
          tmr_load = 1'b1;
          tmr_val  = 5'(T_IORDY_MAX);
        end
      end
      StHold: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = 5'(T_RECOVER);
        end
      end
      default: ;
    endcase
  end

  // Access sequencer with registered bus-side and request-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      wdata_q   <= 16'h0000;
      drive_q   <= 1'b0;
      stretch_q <= 1'b0;
      ata_out   <= 16'h0000;
      ata_done  <= 1'b0;
      ata_busy  <= 1'b0;
      ide_dior  <= 1'b1;
      ide_diow  <= 1'b1;
      ide_cs    <= 2'b11;
      ide_da    <= 3'b000;
    end else begin
      ata_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ata_rd || ata_wr) begin
            // Write wins when both requests are present
            state_q  <= StSetup;
            write_q  <= ata_wr;
            wdata_q  <= ata_in;
            drive_q  <= ata_wr;
            ata_busy <= 1'b1;
            ide_cs   <= {~ata_addr[3], ~ata_addr[4]};
            ide_da   <= ata_addr[2:0];
          end
        end
        StSetup: begin
          if (tmr_expire) begin
            state_q <= StPulse;
            if (write_q) begin
              ide_diow <= 1'b0;
            end else begin
              ide_dior <= 1'b0;
            end
          end
        end
        StPulse: begin
          if (pulse_end) begin
            state_q   <= StHold;
            stretch_q <= 1'b0;
            ide_dior  <= 1'b1;
            ide_diow  <= 1'b1;
            // Sample in the last strobe cycle, before the device releases the bus
            if (!write_q) begin
              ata_out <= ide_data_bus;
            end
          end else if (stretch_start) begin
            stretch_q <= 1'b1;
          end
        end
        StHold: begin
          if (tmr_expire) begin
            state_q  <= StRecov;
            drive_q  <= 1'b0;
            ata_done <= 1'b1;
            ide_cs   <= 2'b11;
            ide_da   <= 3'b000;
          end
        end
        StRecov: begin
          if (tmr_expire) begin
            state_q  <= StIdle;
            ata_busy <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// Directed bench for ide_pio_ctrl (default build, no IORDY stretching).
module tb_ide_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ata_rd = 1'b0;
  logic        ata_wr = 1'b0;
  logic [4:0]  ata_addr = 5'b00000;
  logic [15:0] ata_in = 16'h0000;
  logic [15:0] ata_out;
  logic        ata_done;
  logic        ata_busy;
  wire  [15:0] ide_data_bus;
  logic        ide_dior;
  logic        ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;

  // Device model drives read data while DIOR- is low; probe drives a marker to show release
  localparam logic [15:0] Probe = 16'h8000;
  logic [15:0] dev_data = 16'h0000;
  logic        probe_en = 1'b0;
  assign ide_data_bus = !ide_dior ? dev_data : (probe_en ? Probe : 16'hzzzz);

  int n_checks = 0;
  int n_fail = 0;

  logic        tr_dior [128];
  logic        tr_diow [128];
  logic        tr_done [128];
  logic        tr_busy [128];
  logic [1:0]  tr_cs   [128];
  logic [2:0]  tr_da   [128];
  logic [15:0] tr_bus  [128];

  ide_pio_ctrl u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ata_rd       (ata_rd),
    .ata_wr       (ata_wr),
    .ata_addr     (ata_addr),
    .ata_in       (ata_in),
    .ata_out      (ata_out),
    .ata_done     (ata_done),
    .ata_busy     (ata_busy),
    .ide_data_bus (ide_data_bus),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da)
`ifdef IDE_IORDY_EN
    ,
    .ide_iordy    (1'b1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record n cycles (index = cycles after launch edge); at cycle `scramble` drop requests
  // and change address/data so that later changes can be shown to be ignored.
  task automatic run_trace(input int n, input int scramble);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_dior[i] = ide_dior;
      tr_diow[i] = ide_diow;
      tr_done[i] = ata_done;
      tr_busy[i] = ata_busy;
      tr_cs[i]   = ide_cs;
      tr_da[i]   = ide_da;
      tr_bus[i]  = ide_data_bus;
      if (i == scramble) begin
        ata_rd   = 1'b0;
        ata_wr   = 1'b0;
        ata_addr = 5'b01110;
        ata_in   = 16'hFFFF;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (ata_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (ata_busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  function automatic int n_low(input logic a [128], input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (!a[i]) c++;
    return c;
  endfunction

  function automatic int first_low(input logic a [128], input int n);
    for (int i = 0; i < n; i++) if (!a[i]) return i;
    return -1;
  endfunction

  function automatic int n_high(input logic a [128], input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (a[i]) c++;
    return c;
  endfunction

  function automatic int first_high(input logic a [128], input int n);
    for (int i = 0; i < n; i++) if (a[i]) return i;
    return -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int launches;
    int lpos [4];
    int pairs;
    logic done_seen;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dior", 32'(ide_dior), 32'd1);
    check("rst_diow", 32'(ide_diow), 32'd1);
    check("rst_cs", 32'(ide_cs), 32'd3);
    check("rst_da", 32'(ide_da), 32'd0);
    check("rst_busy_done", {30'd0, ata_busy, ata_done}, 32'd0);
    check("rst_out", 32'(ata_out), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1. Status read
    dev_data = 16'h0050;
    ata_rd   = 1'b1;
    ata_addr = 5'b10111;
    run_trace(33, 0);
    check("c1_dior_width", n_low(tr_dior, 33), 32'd9);
    check("c1_dior_start", first_low(tr_dior, 33), 32'd4);
    check("c1_diow_idle", n_low(tr_diow, 33), 32'd0);
    check("c1_cs", 32'(tr_cs[5]), 32'd2);
    check("c1_da", 32'(tr_da[5]), 32'd7);
    check("c1_cs_recov", 32'(tr_cs[15]), 32'd3);
    check("c1_done_at", first_high(tr_done, 33), 32'd15);
    check("c1_done_cnt", n_high(tr_done, 33), 32'd1);
    check("c1_busy_end", {30'd0, tr_busy[30], tr_busy[31]}, 32'd2);
    check("c1_out", 32'(ata_out), 32'h0050);

    // 2. Write to drive/head
    dev_data = 16'hBEEF;
    probe_en = 1'b1;
    #1;
    check("c2_bus_z_before", 32'(ide_data_bus), 32'(Probe));
    probe_en = 1'b0;
    ata_wr   = 1'b1;
    ata_addr = 5'b10110;
    ata_in   = 16'h0040;
    run_trace(33, 0);
    check("c2_diow_width", n_low(tr_diow, 33), 32'd9);
    check("c2_diow_start", first_low(tr_diow, 33), 32'd4);
    check("c2_dior_idle", n_low(tr_dior, 33), 32'd0);
    check("c2_bus_setup", 32'(tr_bus[0]), 32'h0040);
    check("c2_bus_pulse", 32'(tr_bus[8]), 32'h0040);
    check("c2_bus_hold", 32'(tr_bus[14]), 32'h0040);
    check("c2_cs_da", {27'd0, tr_cs[4], tr_da[4]}, {27'd0, 2'b10, 3'b110});
    check("c2_done_at", first_high(tr_done, 33), 32'd15);
    check("c2_out_kept", 32'(ata_out), 32'h0050);
    probe_en = 1'b1;
    #1;
    check("c2_bus_z_after", 32'(ide_data_bus), 32'(Probe));
    probe_en = 1'b0;

    // 3. Held read polls every 32 cycles
    dev_data = 16'h00D8;
    ata_rd   = 1'b1;
    ata_addr = 5'b10111;
    run_trace(100, 99);
    launches = 0;
    pairs    = 0;
    for (int i = 0; i < 100; i++) begin
      if (tr_busy[i] && (i == 0 || !tr_busy[i-1])) begin
        if (launches < 4) lpos[launches] = i;
        launches++;
      end
      if (i > 0 && tr_done[i] && tr_done[i-1]) pairs++;
    end
    check("c3_launches", launches, 32'd4);
    if (launches == 4) begin
      check("c3_launch1", lpos[1], 32'd32);
      check("c3_launch2", lpos[2], 32'd64);
      check("c3_launch3", lpos[3], 32'd96);
    end
    check("c3_done_cnt", n_high(tr_done, 100), 32'd3);
    check("c3_done_pos", {29'd0, tr_done[15], tr_done[47], tr_done[79]}, 32'd7);
    check("c3_done_wide", pairs, 32'd0);
    check("c3_out", 32'(ata_out), 32'h00D8);
    wait_idle(40);
    repeat (2) @(negedge clk);

    // 4. Both requests: write wins; mid-PULSE changes ignored
    ata_rd   = 1'b1;
    ata_wr   = 1'b1;
    ata_addr = 5'b10111;
    ata_in   = 16'h00EC;
    run_trace(33, 6);
    check("c4_diow_width", n_low(tr_diow, 33), 32'd9);
    check("c4_dior_idle", n_low(tr_dior, 33), 32'd0);
    check("c4_bus_latched", 32'(tr_bus[10]), 32'h00EC);
    check("c4_bus_hold", 32'(tr_bus[14]), 32'h00EC);
    check("c4_cs_da", {27'd0, tr_cs[10], tr_da[10]}, {27'd0, 2'b10, 3'b111});
    check("c4_out_kept", 32'(ata_out), 32'h00D8);
    repeat (2) @(negedge clk);

    // 5. Reset during PULSE of a write aborts at once
    ata_wr   = 1'b1;
    ata_addr = 5'b10111;
    ata_in   = 16'h0020;
    repeat (7) @(negedge clk);
    ata_wr = 1'b0;
    check("c5_in_pulse", 32'(ide_diow), 32'd0);
    reset_n  = 1'b0;
    probe_en = 1'b1;
    #1;
    check("c5_strobes", {30'd0, ide_dior, ide_diow}, 32'd3);
    check("c5_cs", 32'(ide_cs), 32'd3);
    check("c5_busy", 32'(ata_busy), 32'd0);
    check("c5_bus_z", 32'(ide_data_bus), 32'(Probe));
    check("c5_out_rst", 32'(ata_out), 32'd0);
    probe_en  = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      done_seen = done_seen | ata_done;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      done_seen = done_seen | ata_done;
    end
    check("c5_no_done", 32'(done_seen), 32'd0);

    // Read after reset behaves normally
    dev_data = 16'h00D0;
    ata_rd   = 1'b1;
    ata_addr = 5'b10111;
    run_trace(33, 0);
    check("c5_dior_width", n_low(tr_dior, 33), 32'd9);
    check("c5_dior_start", first_low(tr_dior, 33), 32'd4);
    check("c5_done_at", first_high(tr_done, 33), 32'd15);
    check("c5_out", 32'(ata_out), 32'h00D0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
